// File: rtl/core_pkg.sv
// core_pkg: shared command layout, opcode and FSM state types for the rasterizer.
package core_pkg;
    localparam int CMD_W     = 38;
    localparam int OP_W      = 2;
    localparam int COORD_W   = 8;
    localparam int COLOR_W   = 4;
    localparam int OP_LSB    = 36;
    localparam int X0_LSB    = 28;
    localparam int Y0_LSB    = 20;
    localparam int W_LSB     = 12;
    localparam int H_LSB     = 4;
    localparam int COLOR_LSB = 0;
    typedef enum logic [1:0] {OP_NOP = 2'b00, OP_PIXEL = 2'b01, OP_HLINE = 2'b10, OP_RECT = 2'b11} opcode_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;
endpackage

// File: rtl/raster_counter.sv
// raster_counter: row-major cx/cy walk over a w x h pixel block.
module raster_counter
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic [COORD_W-1:0] w,
    input  logic [COORD_W-1:0] h,
    input  logic               advance,
    input  logic               clear,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               last
);
    logic row_end;
    assign row_end = cx == w - COORD_W'(1);
    assign last    = row_end && cy == h - COORD_W'(1);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (advance) begin
            cx <= row_end ? '0 : cx + COORD_W'(1);
            cy <= row_end ? cy + COORD_W'(1) : cy;
        end
    end
endmodule

// File: rtl/core_rasterizer.sv
// core_rasterizer: pops draw commands from a FIFO and streams their pixels
// to a framebuffer writer with valid/ready handshaking.
module core_rasterizer
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               n_rst,
    input  logic               fifo_empty,
    input  logic               fifo_w_enable,
    input  logic [CMD_W-1:0]   fifo_r_data,
    output logic               fifo_r_enable,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               busy,
    output logic               done
);
    state_t              state, next;
    opcode_t             op_q, op_in;
    logic [COORD_W-1:0]  x0_q, y0_q, w_q, h_q, w_in, h_in, eff_w, eff_h, cx, cy;
    logic [COLOR_W-1:0]  color_q;
    logic                skip, last;
    assign op_in = opcode_t'(fifo_r_data[OP_LSB +: OP_W]);
    assign w_in  = fifo_r_data[W_LSB +: COORD_W];
    assign h_in  = fifo_r_data[H_LSB +: COORD_W];
    assign skip  = op_in == OP_NOP || (op_in == OP_HLINE && w_in == '0) ||
                   (op_in == OP_RECT && (w_in == '0 || h_in == '0));
    // PIXEL and HLINE reuse the 2D walk as 1x1 and wx1 blocks
    assign eff_w = op_q == OP_PIXEL ? COORD_W'(1) : w_q;
    assign eff_h = op_q == OP_RECT ? h_q : COORD_W'(1);
    raster_counter u_counter (
        .clk     (clk),
        .n_rst   (n_rst),
        .w       (eff_w),
        .h       (eff_h),
        .advance (px_valid && px_ready),
        .clear   (state != S_DRAW),
        .cx      (cx),
        .cy      (cy),
        .last    (last)
    );
    always_comb begin
        next          = state;
        fifo_r_enable = 1'b0;
        case (state)
            S_IDLE: if (n_rst && !fifo_empty && !fifo_w_enable) begin
                fifo_r_enable = 1'b1;
                next          = S_LOAD;
            end
            S_LOAD: next = skip ? S_DONE : S_DRAW;
            S_DRAW: next = (px_ready && last) ? S_DONE : S_DRAW;
            default: next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            op_q    <= OP_NOP;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
        end else begin
            state <= next;
            if (state == S_LOAD) begin
                op_q    <= op_in;
                x0_q    <= fifo_r_data[X0_LSB +: COORD_W];
                y0_q    <= fifo_r_data[Y0_LSB +: COORD_W];
                w_q     <= w_in;
                h_q     <= h_in;
                color_q <= fifo_r_data[COLOR_LSB +: COLOR_W];
            end
        end
    end
    assign px_valid = state == S_DRAW;
    assign busy     = state != S_IDLE;
    assign done     = state == S_DONE;
    assign px_x     = px_valid ? x0_q + cx : '0;
    assign px_y     = px_valid ? y0_q + cy : '0;
    assign px_color = px_valid ? color_q : '0;
endmodule

// File: tb/tb_core_rasterizer.sv
// tb_core_rasterizer: directed vectors for core_rasterizer with hand-computed pixels.
module tb_core_rasterizer;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        fifo_w_enable = 1'b0;
    logic [37:0] fifo_r_data = '0;
    logic        fifo_r_enable;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic [7:0]  px_x, px_y;
    logic [3:0]  px_color;
    logic        busy, done;
    int          vectors = 0;
    int          miscompares = 0;

    core_rasterizer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .fifo_empty    (fifo_empty),
        .fifo_w_enable (fifo_w_enable),
        .fifo_r_data   (fifo_r_data),
        .fifo_r_enable (fifo_r_enable),
        .px_valid      (px_valid),
        .px_ready      (px_ready),
        .px_x          (px_x),
        .px_y          (px_y),
        .px_color      (px_color),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] mk(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] w, input logic [7:0] h, input logic [3:0] c);
        return {op, x, y, w, h, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pop(input string tag, input logic [37:0] c);
        tick();
        fifo_r_data = c;
        fifo_empty  = 1'b0;
        #1;
        chk({tag, "_pop"}, 32'(fifo_r_enable), 1);
        tick();
        fifo_empty = 1'b1;
        #1;
        chk({tag, "_load_busy"}, 32'(busy), 1);
        chk({tag, "_load_valid"}, 32'(px_valid), 0);
        chk({tag, "_load_pop"}, 32'(fifo_r_enable), 0);
    endtask

    task automatic pix_chk(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [3:0] c);
        chk({tag, "_valid"}, 32'(px_valid), 1);
        chk({tag, "_x"}, 32'(px_x), 32'(x));
        chk({tag, "_y"}, 32'(px_y), 32'(y));
        chk({tag, "_color"}, 32'(px_color), 32'(c));
        chk({tag, "_nodone"}, 32'(done), 0);
    endtask

    task automatic pix(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [3:0] c);
        tick();
        pix_chk(tag, x, y, c);
    endtask

    task automatic fin(input string tag);
        tick();
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_done_valid"}, 32'(px_valid), 0);
        tick();
        chk({tag, "_done_clear"}, 32'(done), 0);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        int i;
        #2;
        chk("rst_pop", 32'(fifo_r_enable), 0);
        chk("rst_valid", 32'(px_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_xyc", {8'd0, px_x, px_y, 4'd0, px_color}, 0);
        tick();
        n_rst = 1'b1;
        tick();
        chk("idle_empty_pop", 32'(fifo_r_enable), 0);

        pop("pixel", mk(2'b01, 8'd10, 8'd20, 8'd7, 8'd3, 4'd5));
        pix("pixel", 8'd10, 8'd20, 4'd5);
        fin("pixel");

        pop("rect", mk(2'b11, 8'd3, 8'd4, 8'd2, 8'd2, 4'd9));
        pix("rect0", 8'd3, 8'd4, 4'd9);
        pix("rect1", 8'd4, 8'd4, 4'd9);
        pix("rect2", 8'd3, 8'd5, 4'd9);
        pix("rect3", 8'd4, 8'd5, 4'd9);
        fin("rect");

        pop("hline", mk(2'b10, 8'd254, 8'd0, 8'd4, 8'd7, 4'd3));
        pix("hline0", 8'd254, 8'd0, 4'd3);
        pix("hline1", 8'd255, 8'd0, 4'd3);
        pix("hline2", 8'd0, 8'd0, 4'd3);
        pix("hline3", 8'd1, 8'd0, 4'd3);
        fin("hline");

        pop("stall", mk(2'b11, 8'd100, 8'd50, 8'd3, 8'd2, 4'd12));
        i = 0;
        for (int cyc = 0; cyc < 20 && i < 6; cyc++) begin
            tick();
            px_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            pix_chk($sformatf("stall_c%0d", cyc), 8'(100 + i % 3), 8'(50 + i / 3), 4'd12);
            if (px_ready) i++;
        end
        chk("stall_count", 32'(i), 6);
        px_ready = 1'b1;
        fin("stall");

        tick();
        fifo_r_data   = mk(2'b00, 8'd1, 8'd2, 8'd3, 8'd4, 4'd5);
        fifo_empty    = 1'b0;
        fifo_w_enable = 1'b1;
        #1;
        chk("push0_pop", 32'(fifo_r_enable), 0);
        tick();
        chk("push1_pop", 32'(fifo_r_enable), 0);
        chk("push1_idle", 32'(busy), 0);
        tick();
        fifo_w_enable = 1'b0;
        #1;
        chk("nopush_pop", 32'(fifo_r_enable), 1);
        tick();
        fifo_empty = 1'b1;
        #1;
        chk("nop_load_pop", 32'(fifo_r_enable), 0);
        chk("nop_load_valid", 32'(px_valid), 0);
        fin("nop");

        pop("rect_w0", mk(2'b11, 8'd9, 8'd9, 8'd0, 8'd5, 4'd1));
        fin("rect_w0");

        pop("abort", mk(2'b11, 8'd5, 8'd6, 8'd4, 8'd4, 4'd7));
        pix("abort0", 8'd5, 8'd6, 4'd7);
        pix("abort1", 8'd6, 8'd6, 4'd7);
        n_rst = 1'b0;
        #1;
        chk("abort_valid", 32'(px_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_pop", 32'(fifo_r_enable), 0);
        chk("abort_xyc", {8'd0, px_x, px_y, 4'd0, px_color}, 0);
        tick();
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("post_abort%0d_done", k), 32'(done), 0);
            chk($sformatf("post_abort%0d_valid", k), 32'(px_valid), 0);
            chk($sformatf("post_abort%0d_busy", k), 32'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/core_rasterizer.md
CORE_RASTERIZER -- requirements
Module: core_rasterizer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port fifo_empty, input, 1 bit: command FIFO holds no entries.
REQ-004 SHALL have port fifo_w_enable, input, 1 bit: tap of the command FIFO's push strobe; the FIFO ignores a pop in any cycle it pushes.
REQ-005 SHALL have port fifo_r_data, input, 38 bits: registered FIFO head output, valid the cycle after an accepted pop.
REQ-006 SHALL have port fifo_r_enable, output, 1 bit: pop request to the command FIFO.
REQ-007 SHALL have port px_valid, output, 1 bit: a pixel write is presented.
REQ-008 SHALL have port px_ready, input, 1 bit: the framebuffer writer accepts the pixel this cycle.
REQ-009 SHALL have ports px_x and px_y, outputs, 8 bits each: pixel coordinates.
REQ-010 SHALL have port px_color, output, 4 bits: pixel colour index.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a command completes.

Function
REQ-013 SHALL decode commands as [37:36] opcode (00 NOP, 01 PIXEL, 10 HLINE, 11 RECT), [35:28] x0, [27:20] y0, [19:12] w, [11:4] h, [3:0] color.
REQ-014 SHALL implement the FSM states IDLE, LOAD, DRAW and DONE.
REQ-015 SHALL, in IDLE when fifo_empty=0 and fifo_w_enable=0, drive fifo_r_enable=1 for exactly one cycle and move to LOAD.
REQ-016 SHALL, in IDLE when fifo_empty=1 or fifo_w_enable=1, keep fifo_r_enable=0 and stay in IDLE; a pop is never issued alongside a push.
REQ-017 SHALL assert fifo_r_enable only in IDLE.
REQ-018 SHALL, in LOAD, latch all fields of fifo_r_data into internal command registers.
REQ-019 SHALL, from LOAD, go to DONE for NOP, or for HLINE with w=0, or for RECT with w=0 or h=0; every other command goes to DRAW.
REQ-020 SHALL, for PIXEL, emit one pixel at (x0,y0), with w and h ignored.
REQ-021 SHALL, for HLINE, emit w pixels at x0..x0+w-1 on row y0, with h ignored.
REQ-022 SHALL, for RECT, emit w*h pixels in row-major order: cx 0..w-1 inner, cy 0..h-1 outer.
REQ-023 SHALL compute px_x=(x0+cx) mod 256 and px_y=(y0+cy) mod 256, so coordinates wrap with no error.
REQ-024 SHALL drive px_color=color for every pixel of a command.
REQ-025 SHALL hold px_valid=1 throughout DRAW.
REQ-026 SHALL hold px_x, px_y and px_color stable while px_valid=1 and px_ready=0.
REQ-027 SHALL advance cx and cy only on cycles with px_valid=1 and px_ready=1.
REQ-028 SHALL move from DRAW to DONE on the cycle the last pixel is accepted.
REQ-029 SHALL, in DONE, drive done=1 for one cycle and then return to IDLE.
REQ-030 SHALL have first-pixel latency of 2 cycles: pop in cycle N, LOAD in N+1, px_valid in N+2.
REQ-031 SHALL sustain 1 pixel/cycle when px_ready=1, with 3 cycles of overhead per command.
REQ-032 SHALL ignore fifo_r_data outside LOAD.

Reset
REQ-033 SHALL, while n_rst=0, force state=IDLE, cx=cy=0, command registers=0, and fifo_r_enable=px_valid=busy=done=0 and px_x=px_y=px_color=0.
REQ-034 SHALL, on reset mid-command, abort the command with no done pulse and no further pixels, leave the popped command lost, and resume from IDLE.

Structure
REQ-035 SHALL take from shared package core_pkg the opcode enum, the command field bit positions and widths, the FSM state enum, and CMD_W=38.
REQ-036 SHALL place the cx/cy 2D counter (inputs w, h, advance, clear; output last) in sub-module raster_counter.

Verification
REQ-037 SHALL verify: PIXEL x0=10 y0=20 color=5, px_ready=1 -> a single pixel (10,20,5) two cycles after the pop, done pulses the following cycle.
REQ-038 SHALL verify: RECT x0=3 y0=4 w=2 h=2 -> pixels (3,4),(4,4),(3,5),(4,5) on consecutive cycles, then one done pulse.
REQ-039 SHALL verify: HLINE x0=254 w=4 y0=0 -> px_x sequence 254,255,0,1 with px_y=0 throughout.
REQ-040 SHALL verify: px_ready held low for 3 cycles mid-RECT -> outputs frozen and no pixel skipped or duplicated.
REQ-041 SHALL verify: fifo_empty=0 with fifo_w_enable=1 for 2 cycles -> fifo_r_enable stays 0, then pulses once on the first cycle fifo_w_enable=0.
REQ-042 SHALL verify: RECT w=0 h=5 and NOP -> no px_valid, done pulses 2 cycles after pop; n_rst asserted mid-RECT -> all outputs 0 immediately and no done.
